// File: rtl/sm4_pkg.sv
// Shared SM4 constants and key-schedule controller state encoding.
package sm4_pkg;

  localparam int unsigned SM4_ROUNDS = 32;
  localparam logic [4:0]  SM4_LAST_ROUND = 5'(SM4_ROUNDS - 1);

  localparam logic [31:0] SM4_FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] SM4_FK1 = 32'h56AA3350;
  localparam logic [31:0] SM4_FK2 = 32'h677D9197;
  localparam logic [31:0] SM4_FK3 = 32'hB27022DC;
  localparam logic [127:0] SM4_FK = {SM4_FK0, SM4_FK1, SM4_FK2, SM4_FK3};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_CALC = 3'd3,
    ST_FIN  = 3'd4
  } sm4_ks_state_e;

endpackage

// File: rtl/sm4_rk_store.sv
// 32x32 round-key store with forward/reverse read and one-cycle registered read port.
module sm4_rk_store
  import sm4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_idx,
  input  logic        rd_dec,
  input  logic        busy,
  output logic [31:0] rd_key
);

  logic [31:0] mem_q [SM4_ROUNDS];
  logic [4:0]  rd_addr_s;
  logic [31:0] rd_key_d;
  logic [31:0] rd_key_q;

  // Decryption order reads the schedule back to front; reads are blanked mid-expansion.
  always_comb begin
    rd_addr_s = rd_dec ? (SM4_LAST_ROUND - rd_idx) : rd_idx;
    rd_key_d  = busy ? 32'h0000_0000 : mem_q[rd_addr_s];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_key_q <= 32'h0000_0000;
    end else begin
      rd_key_q <= rd_key_d;
    end
  end

  assign rd_key = rd_key_q;

endmodule

// File: rtl/sm4_key_sched_ctrl.sv
// SM4 key expansion controller driving an external CK ROM and shared T' transform.
// Optional round-key store enabled by defining SM4_KEY_STORE_EN.
module sm4_key_sched_ctrl
  import sm4_pkg::*;
#(
  parameter int unsigned CK_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic [4:0]   round_idx,
  input  logic [31:0]  ck_in,
  output logic [31:0]  tp_arg,
  input  logic [31:0]  tp_res,
  output logic         rk_valid,
  output logic [4:0]   rk_idx,
  output logic [31:0]  rk_out
`ifdef SM4_KEY_STORE_EN
  ,
  input  logic [4:0]   rd_idx,
  input  logic         rd_dec,
  output logic [31:0]  rd_key
`endif
);

  localparam logic [1:0] WAIT_LAST = 2'(CK_LAT - 1);

  sm4_ks_state_e state_q, state_d;
  logic [4:0]  round_q, round_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  round_idx_q, round_idx_d;
  logic        rk_valid_q, rk_valid_d;
  logic [4:0]  rk_idx_q, rk_idx_d;
  logic [31:0] rk_out_q, rk_out_d;
  logic [31:0] tp_arg_s;
  logic [31:0] rk_s;

  // K registers first hold MK (captured with start) and are whitened with FK in LOAD.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    wait_cnt_d = wait_cnt_q;
    k0_d       = k0_q;
    k1_d       = k1_q;
    k2_d       = k2_q;
    k3_d       = k3_q;
    done_d     = 1'b0;
    rk_valid_d = 1'b0;
    rk_idx_d   = rk_idx_q;
    rk_out_d   = rk_out_q;
    tp_arg_s   = 32'h0000_0000;
    rk_s       = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          {k0_d, k1_d, k2_d, k3_d} = key_in;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        {k0_d, k1_d, k2_d, k3_d} = {k0_q, k1_q, k2_q, k3_q} ^ SM4_FK;
        state_d    = ST_WAIT;
        wait_cnt_d = 2'd0;
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_CALC;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      ST_CALC: begin
        tp_arg_s   = k1_q ^ k2_q ^ k3_q ^ ck_in;
        rk_s       = k0_q ^ tp_res;
        rk_valid_d = 1'b1;
        rk_idx_d   = round_q;
        rk_out_d   = rk_s;
        k0_d       = k1_q;
        k1_d       = k2_q;
        k2_d       = k3_q;
        k3_d       = rk_s;
        if (round_q == SM4_LAST_ROUND) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          state_d    = ST_WAIT;
          round_d    = round_q + 5'd1;
          wait_cnt_d = 2'd0;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        round_d = 5'd0;
      end
      default: begin
        state_d = ST_IDLE;
        round_d = 5'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    if ((state_d == ST_LOAD) || (state_d == ST_WAIT) || (state_d == ST_CALC)) begin
      round_idx_d = round_d;
    end else begin
      round_idx_d = 5'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      round_q     <= 5'd0;
      wait_cnt_q  <= 2'd0;
      k0_q        <= 32'h0000_0000;
      k1_q        <= 32'h0000_0000;
      k2_q        <= 32'h0000_0000;
      k3_q        <= 32'h0000_0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      round_idx_q <= 5'd0;
      rk_valid_q  <= 1'b0;
      rk_idx_q    <= 5'd0;
      rk_out_q    <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      wait_cnt_q  <= wait_cnt_d;
      k0_q        <= k0_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      k3_q        <= k3_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      round_idx_q <= round_idx_d;
      rk_valid_q  <= rk_valid_d;
      rk_idx_q    <= rk_idx_d;
      rk_out_q    <= rk_out_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign round_idx = round_idx_q;
  assign tp_arg    = tp_arg_s;
  assign rk_valid  = rk_valid_q;
  assign rk_idx    = rk_idx_q;
  assign rk_out    = rk_out_q;

`ifdef SM4_KEY_STORE_EN
  sm4_rk_store u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rk_valid_q),
    .wr_idx  (rk_idx_q),
    .wr_data (rk_out_q),
    .rd_idx  (rd_idx),
    .rd_dec  (rd_dec),
    .busy    (busy_q),
    .rd_key  (rd_key)
  );
`endif

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Directed bench for sm4_key_sched_ctrl at CK_LAT=1 and CK_LAT=3 with a behavioural CK ROM and T'.
module tb_sm4_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key_in = 128'h0123456789ABCDEFFEDCBA9876543210;
  logic         start_1 = 1'b0, start_3 = 1'b0;
  logic         busy_1, busy_3, done_1, done_3, rk_valid_1, rk_valid_3;
  logic [4:0]   round_idx_1, round_idx_3, rk_idx_1, rk_idx_3;
  logic [31:0]  tp_arg_1, tp_arg_3, tp_res_1, tp_res_3, rk_out_1, rk_out_3;
  logic [31:0]  ck1_q, ck3_a, ck3_b, ck3_c;
  logic [31:0]  ref_rk [32];
  int           n_chk = 0;
  int           n_err = 0;
`ifdef SM4_KEY_STORE_EN
  logic [4:0]   rd_idx_1 = 5'd0, rd_idx_3 = 5'd0;
  logic         rd_dec_1 = 1'b0, rd_dec_3 = 1'b0;
  logic [31:0]  rd_key_1, rd_key_3;
`endif

  always #5 clk = ~clk;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [127:0] row;
    case (x[7:4])
      4'h0: row = 128'hd690e9fecce13db716b614c228fb2c05;
      4'h1: row = 128'h2b679a762abe04c3aa44132649860699;
      4'h2: row = 128'h9c4250f491ef987a33540b43edcfac62;
      4'h3: row = 128'he4b31ca9c908e89580df94fa758f3fa6;
      4'h4: row = 128'h4707a7fcf37317ba83593c19e6854fa8;
      4'h5: row = 128'h686b81b27164da8bf8eb0f4b70569d35;
      4'h6: row = 128'h1e240e5e6358d1a225227c3b01217887;
      4'h7: row = 128'hd40046579fd327524c3602e7a0c4c89e;
      4'h8: row = 128'heabf8ad240c738b5a3f7f2cef96115a1;
      4'h9: row = 128'he0ae5da49b341a55ad933230f58cb1e3;
      4'ha: row = 128'h1df6e22e8266ca60c02923ab0d534e6f;
      4'hb: row = 128'hd5db3745defd8e2f03ff6a726d6c5b51;
      4'hc: row = 128'h8d1baf92bbddbc7f11d95c411f105ad8;
      4'hd: row = 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0;
      4'he: row = 128'h8969974a0c96777e65b9f109c56ec684;
      default: row = 128'h18f07dec3adc4d2079ee5f3ed7cb3948;
    endcase
    return row[127 - 8 * int'(x[3:0]) -: 8];
  endfunction

  function automatic logic [31:0] tprime(input logic [31:0] a);
    logic [31:0] b;
    b = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  function automatic logic [31:0] ck_const(input logic [4:0] i);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) begin
      r[31 - 8 * j -: 8] = 8'(((4 * int'(i) + j) * 7) % 256);
    end
    return r;
  endfunction

  assign tp_res_1 = tprime(tp_arg_1);
  assign tp_res_3 = tprime(tp_arg_3);

  // External CK ROM models: one and three register stages.
  always @(posedge clk) begin
    ck1_q <= ck_const(round_idx_1);
    ck3_a <= ck_const(round_idx_3);
    ck3_b <= ck3_a;
    ck3_c <= ck3_b;
  end

  sm4_key_sched_ctrl #(.CK_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_1), .key_in(key_in), .busy(busy_1), .done(done_1),
    .round_idx(round_idx_1), .ck_in(ck1_q), .tp_arg(tp_arg_1), .tp_res(tp_res_1),
    .rk_valid(rk_valid_1), .rk_idx(rk_idx_1), .rk_out(rk_out_1)
`ifdef SM4_KEY_STORE_EN
    , .rd_idx(rd_idx_1), .rd_dec(rd_dec_1), .rd_key(rd_key_1)
`endif
  );

  sm4_key_sched_ctrl #(.CK_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_3), .key_in(key_in), .busy(busy_3), .done(done_3),
    .round_idx(round_idx_3), .ck_in(ck3_c), .tp_arg(tp_arg_3), .tp_res(tp_res_3),
    .rk_valid(rk_valid_3), .rk_idx(rk_idx_3), .rk_out(rk_out_3)
`ifdef SM4_KEY_STORE_EN
    , .rd_idx(rd_idx_3), .rd_dec(rd_dec_3), .rd_key(rd_key_3)
`endif
  );

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_start(input bit sel3, input logic v);
    if (sel3) start_3 = v;
    else      start_1 = v;
  endtask

  // Runs one expansion; cycle 0 is the cycle start is high. Optionally re-pulses start
  // at pulse_cyc, and with chain raises start in the first idle cycle after done.
  task automatic expand(input bit sel3, input int pulse_cyc, input bit chain, input bit started);
    int cyc, nk, lat, bad_busy, bad_stab;
    int ridx_cnt [32];
    bit got_done;
    logic v, d, b;
    logic [4:0] ix, ri;
    logic [31:0] ro;
    lat = sel3 ? 3 : 1;
    cyc = 0; nk = 0; bad_busy = 0; bad_stab = 0; got_done = 1'b0;
    for (int r = 0; r < 32; r++) ridx_cnt[r] = 0;
    if (!started) begin
      @(negedge clk);
      drive_start(sel3, 1'b1);
    end
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      drive_start(sel3, (cyc == pulse_cyc));
      v  = sel3 ? rk_valid_3 : rk_valid_1;
      d  = sel3 ? done_3 : done_1;
      b  = sel3 ? busy_3 : busy_1;
      ix = sel3 ? rk_idx_3 : rk_idx_1;
      ri = sel3 ? round_idx_3 : round_idx_1;
      ro = sel3 ? rk_out_3 : rk_out_1;
      if (b !== 1'b1) bad_busy++;
      ridx_cnt[ri]++;
`ifdef SM4_KEY_STORE_EN
      if (cyc == 10) check32("rd_key_busy", sel3 ? rd_key_3 : rd_key_1, 32'h0);
`endif
      if (v === 1'b1) begin
        check32("rk_idx_order", 32'(ix), 32'(nk));
        check32("rk_value", ro, ref_rk[ix]);
        if (ix == 5'd0)  check32("rk0_vector", ro, 32'hF12186F9);
        if (ix == 5'd1)  check32("rk1_vector", ro, 32'h41662B61);
        if (ix == 5'd31) check32("rk31_vector", ro, 32'h9124A012);
        nk++;
      end
      if (d === 1'b1) begin
        got_done = 1'b1;
        check32("done_latency", 32'(cyc), 32'(2 + 32 * (lat + 1)));
        check32("done_with_key31", {26'd0, v, ix}, {26'd0, 1'b1, 5'd31});
      end
    end
    check32("done_seen", 32'(got_done), 32'd1);
    check32("key_count", 32'(nk), 32'd32);
    check32("busy_during_run", 32'(bad_busy), 32'd0);
    for (int r = 1; r < 32; r++) if (ridx_cnt[r] != lat + 1) bad_stab++;
    check32("round_idx_stable", 32'(bad_stab), 32'd0);
    @(negedge clk);
    check32("busy_gap", 32'(sel3 ? busy_3 : busy_1), 32'd0);
    drive_start(sel3, chain);
  endtask

  initial begin
    int ev;
    logic [127:0] k;
    logic [31:0]  rk;
    k = key_in ^ 128'hA3B1BAC656AA3350677D9197B27022DC;
    for (int i = 0; i < 32; i++) begin
      rk = k[127:96] ^ tprime(k[95:64] ^ k[63:32] ^ k[31:0] ^ ck_const(5'(i)));
      ref_rk[i] = rk;
      k = {k[95:0], rk};
    end

    repeat (2) @(negedge clk);
    check32("rst_busy", 32'(busy_1), 32'd0);
    check32("rst_outs", {22'd0, done_1, rk_valid_1, rk_idx_1, round_idx_1}, 32'd0);
    check32("rst_rk_out", rk_out_1, 32'h0);
    check32("rst_tp_arg", tp_arg_1, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    expand(1'b0, -1, 1'b0, 1'b0);

`ifdef SM4_KEY_STORE_EN
    rd_idx_1 = 5'd0; rd_dec_1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check32("store_dec0", rd_key_1, 32'h9124A012);
    rd_dec_1 = 1'b0;
    @(negedge clk);
    check32("store_fwd0", rd_key_1, 32'hF12186F9);
    rd_idx_1 = 5'd5; rd_dec_1 = 1'b1;
    @(negedge clk);
    check32("store_dec5", rd_key_1, ref_rk[26]);
`endif

    // Start re-pulsed during round 10's WAIT cycle must be ignored.
    expand(1'b0, 22, 1'b0, 1'b0);

    // Abort in round 17, then confirm silence and a clean restart.
    @(negedge clk);
    start_1 = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      start_1 = 1'b0;
    end
    check32("pre_rst_round", 32'(round_idx_1), 32'd17);
    rst = 1'b1;
    @(negedge clk);
    check32("mid_rst_busy", 32'(busy_1), 32'd0);
    check32("mid_rst_outs", {22'd0, done_1, rk_valid_1, rk_idx_1, round_idx_1}, 32'd0);
    check32("mid_rst_rk_out", rk_out_1, 32'h0);
    check32("mid_rst_tp_arg", tp_arg_1, 32'h0);
    rst = 1'b0;
    ev = 0;
    repeat (10) begin
      @(negedge clk);
      if (rk_valid_1 !== 1'b0 || done_1 !== 1'b0 || busy_1 !== 1'b0) ev++;
    end
    check32("abort_quiet", 32'(ev), 32'd0);
    expand(1'b0, -1, 1'b0, 1'b0);

    // Back-to-back expansions with start in the cycle after done.
    expand(1'b0, -1, 1'b1, 1'b0);
    expand(1'b0, -1, 1'b0, 1'b1);

    expand(1'b1, -1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sm4_key_sched_ctrl.md
SM4_KEY_SCHED_CTRL -- requirements
Module: sm4_key_sched_ctrl

Interface
REQ-001 SHALL have parameter CK_LAT, default 1, meaning cycles from round_idx change to valid ck_in (1..3).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request key expansion; sampled in IDLE only.
REQ-005 SHALL have port key_in  input  128  user key MK0..MK3, MK0 in [127:96]; sampled with start.
REQ-006 SHALL have port busy  output  1  expansion in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse after round key 31.
REQ-008 SHALL have port round_idx  output  5  round index driven to the CK constant ROM.
REQ-009 SHALL have port ck_in  input  32  CK constant returned CK_LAT cycles after round_idx.
REQ-010 SHALL have port tp_arg  output  32  argument to the shared key transform T' (S-box plus L').
REQ-011 SHALL have port tp_res  input  32  combinational T'(tp_arg) from the shared transform.
REQ-012 SHALL have port rk_valid  output  1  round key strobe.
REQ-013 SHALL have port rk_idx  output  5  index of the strobed round key.
REQ-014 SHALL have port rk_out  output  32  round key value.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, WAIT, CALC, FIN.
- IDLE->LOAD on start.
- LOAD->WAIT: registers K0..K3 = MK ^ FK.
- WAIT holds CK_LAT cycles->CALC.
- CALC->WAIT while round < 31.
- CALC->FIN at round 31.
- FIN->IDLE unconditionally.
REQ-016 SHALL use FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC for K0..K3.
REQ-017 SHALL set round_idx to the current round in LOAD/WAIT/CALC and hold it stable from WAIT entry through CALC.
REQ-018 SHALL drive tp_arg = K1^K2^K3^ck_in in CALC only, and 0 otherwise.
REQ-019 SHALL in CALC compute rk = K0^tp_res, assert rk_valid with rk_idx = round, shift K0<-K1, K1<-K2, K2<-K3, K3<-rk, and increment round.
REQ-020 SHALL produce keys in order 0..31; each round takes CK_LAT+1 cycles; start-to-done latency is 2+32*(CK_LAT+1) cycles.
REQ-021 SHALL register rk_valid, rk_idx and rk_out, so they are visible the cycle after CALC; done SHALL be asserted in FIN, coincident with visibility of key 31.
REQ-022 SHALL assert busy in LOAD, WAIT, CALC and FIN.
REQ-023 SHALL ignore start while busy, and SHALL NOT queue it.
REQ-024 SHALL wrap round from 31 to 0 only via FIN->IDLE; round SHALL never exceed 31.
REQ-025 SHALL accept start in the cycle after done, which begins a new expansion.

Reset
REQ-026 SHALL, on rst assertion at any time (including mid-expansion), go immediately to IDLE and clear the following to 0: round, K0..K3, busy, done, rk_valid, rk_idx, rk_out, round_idx, tp_arg.
REQ-027 SHALL emit no rk_valid and no done for an expansion aborted by reset.

Configuration
REQ-028 SHALL, with SM4_KEY_STORE_EN defined, include a 32x32 internal round-key store written on each rk_valid. It adds:
- input rd_idx (5);
- input rd_dec (1): when set, reads index 31-rd_idx;
- output rd_key (32): registered, one-cycle read latency, reads 0 while busy.
REQ-029 SHALL, without SM4_KEY_STORE_EN, omit the store and the rd_* ports; keys are streamed only.

Structure
REQ-030 SHALL place the FK constants, the FSM state enum and the SM4_ROUNDS=32 constant in shared package sm4_pkg.
REQ-031 SHALL, when enabled, implement the store as sub-module sm4_rk_store. The CK ROM and T' are external, shared with the encryption datapath.

Verification
REQ-032 SHALL check: key 0123456789ABCDEFFEDCBA9876543210, start -> rk_idx 0 = F12186F9, rk_idx 1 = 41662B61, rk_idx 31 = 9124A012, done after 66 cycles (CK_LAT=1).
REQ-033 SHALL check: start re-pulsed at round 10 -> ignored; key sequence identical to REQ-032.
REQ-034 SHALL check: rst at round 17 -> all outputs 0 next cycle; new start gives a full correct sequence.
REQ-035 SHALL check: CK_LAT=3 -> round_idx stable 4 cycles per round; done after 130 cycles; same keys.
REQ-036 SHALL check: SM4_KEY_STORE_EN defined, rd_idx=0, rd_dec=1 after done -> rd_key = 9124A012 one cycle later.
REQ-037 SHALL check: start in the cycle after done -> accepted; busy stays low for one cycle only.
